// File: rtl/approx_sweep_err_meter.sv
// Exhaustive-sweep error meter: walks pi over every input vector, samples the exact and
// approximate partition outputs after a settle interval, and accumulates error metrics.
module approx_sweep_err_meter #(
  parameter int NI     = 7,
  parameter int NO     = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [NI-1:0]     pi,
  input  logic [NO-1:0]     po_exact,
  input  logic [NO-1:0]     po_approx,
  output logic              busy,
  output logic              done,
  output logic [NI:0]       err_cnt,
  output logic [NI+4:0]     hd_sum,
  output logic [NI+NO-1:0]  abs_sum,
  output logic [NO-1:0]     max_abs
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0]    SETTLE_C = 8'(SETTLE);
  localparam logic [NI-1:0] PI_LAST  = {NI{1'b1}};

  state_t        state_r;
  logic [7:0]    cnt_r;
  logic [NO-1:0] diff_s;
  logic [4:0]    pop_s;
  logic          mismatch_s;

  function automatic logic [4:0] popcount(input logic [NO-1:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < NO; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  // Operands are unsigned, so subtract the smaller from the larger.
  function automatic logic [NO-1:0] abs_diff(input logic [NO-1:0] a, input logic [NO-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Per-vector metrics of the currently presented partition outputs.
  always_comb begin
    diff_s     = abs_diff(po_exact, po_approx);
    pop_s      = popcount(po_exact ^ po_approx);
    mismatch_s = (po_exact != po_approx);
  end

  // Sweep controller, vector driver and metric accumulators.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= 8'd0;
      pi      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err_cnt <= '0;
      hd_sum  <= '0;
      abs_sum <= '0;
      max_abs <= '0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_r <= S_WAIT;
            cnt_r   <= SETTLE_C;
            pi      <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            err_cnt <= '0;
            hd_sum  <= '0;
            abs_sum <= '0;
            max_abs <= '0;
          end
        end
        S_WAIT: begin
          if (abort) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
          end else begin
            err_cnt <= err_cnt + (NI+1)'(mismatch_s);
            hd_sum  <= hd_sum + (NI+5)'(pop_s);
            abs_sum <= abs_sum + (NI+NO)'(diff_s);
            if (diff_s > max_abs) begin
              max_abs <= diff_s;
            end
            if (pi == PI_LAST) begin
              state_r <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              pi    <= pi + NI'(1);
              cnt_r <= SETTLE_C;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_sweep_err_meter.sv
// Scoreboard bench: two meters (SETTLE=1 and SETTLE=3) driven from lookup-table partitions,
// with expected metrics computed directly from the tables.
module tb_approx_sweep_err_meter;
  localparam int NI = 7;
  localparam int NO = 4;
  localparam int NV = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start1 = 1'b0, abort1 = 1'b0, start3 = 1'b0, abort3 = 1'b0;
  logic [NI-1:0] pi1, pi3;
  logic [NO-1:0] pe1, pa1, pe3, pa3;
  logic busy1, done1, busy3, done3;
  logic [NI:0] ec1, ec3;
  logic [NI+4:0] hd1, hd3;
  logic [NI+NO-1:0] ab1, ab3;
  logic [NO-1:0] mx1, mx3;

  logic [NO-1:0] ex_tab[NV];
  logic [NO-1:0] ap_tab[NV];
  assign pe1 = ex_tab[pi1];
  assign pa1 = ap_tab[pi1];
  assign pe3 = ex_tab[pi3];
  assign pa3 = ap_tab[pi3];

  approx_sweep_err_meter #(.NI(NI), .NO(NO), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .pi(pi1),
    .po_exact(pe1), .po_approx(pa1), .busy(busy1), .done(done1),
    .err_cnt(ec1), .hd_sum(hd1), .abs_sum(ab1), .max_abs(mx1));

  approx_sweep_err_meter #(.NI(NI), .NO(NO), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .pi(pi3),
    .po_exact(pe3), .po_approx(pa3), .busy(busy3), .done(done3),
    .err_cnt(ec3), .hd_sum(hd3), .abs_sum(ab3), .max_abs(mx3));

  typedef struct {
    int err; int hd; int abs_s; int mx; int dn; int start_cyc; int edges;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference metrics over vectors 0..nvec-1 straight from the partition tables.
  function automatic exp_t model(int nvec);
    exp_t e;
    e.err = 0; e.hd = 0; e.abs_s = 0; e.mx = 0; e.dn = 1; e.start_cyc = 0; e.edges = 0;
    for (int v = 0; v < nvec; v++) begin
      int a, b, d, x;
      a = int'(ex_tab[v]);
      b = int'(ap_tab[v]);
      d = (a > b) ? a - b : b - a;
      x = a ^ b;
      if (a != b) e.err++;
      for (int k = 0; k < NO; k++) e.hd += (x >> k) & 1;
      e.abs_s += d;
      if (d > e.mx) e.mx = d;
    end
    return e;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_end(string tag, exp_t e, int ec, int hd, int ab, int mx, int dn);
    chk({tag, " err_cnt"}, ec, e.err);
    chk({tag, " hd_sum"}, hd, e.hd);
    chk({tag, " abs_sum"}, ab, e.abs_s);
    chk({tag, " max_abs"}, mx, e.mx);
    chk({tag, " done"}, dn, e.dn);
    if (e.dn != 0) chk({tag, " done latency"}, cyc - e.start_cyc + 1, e.edges);
  endtask

  // Monitor: whenever a meter leaves WAIT, pop its expectation and compare.
  logic pb1 = 1'b0, pb3 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (pb1 && !busy1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected end: got end-of-sweep required none");
      end else begin
        e = q1.pop_front();
        check_end("dut1", e, int'(ec1), int'(hd1), int'(ab1), int'(mx1), int'(done1));
      end
    end
    if (pb3 && !busy3) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut3 unexpected end: got end-of-sweep required none");
      end else begin
        e = q3.pop_front();
        check_end("dut3", e, int'(ec3), int'(hd3), int'(ab3), int'(mx3), int'(done3));
      end
    end
    pb1 <= busy1;
    pb3 <= busy3;
  end

  task automatic start_sweep(int sel, exp_t e);
    @(negedge clk);
    if (sel == 1) start1 = 1'b1; else start3 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start3 = 1'b0;
    e.start_cyc = cyc;
    if (sel == 1) q1.push_back(e); else q3.push_back(e);
  endtask

  task automatic wait_end(int sel, int budget, string tag);
    bit ended;
    ended = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel == 1) ? !busy1 : !busy3) begin
        ended = 1'b1;
        break;
      end
    end
    if (!ended) begin
      checks++; errors++;
      $display("FAIL %s timeout: got busy after %0d cycles required idle", tag, budget);
    end
    @(negedge clk);
  endtask

  task automatic run_full(int sel, string tag);
    exp_t e;
    int s;
    s = (sel == 1) ? 1 : 3;
    e = model(NV);
    e.edges = 1 + NV * (s + 1);
    start_sweep(sel, e);
    wait_end(sel, NV * (s + 1) + 20, tag);
  endtask

  task automatic set_tables(int mode);
    for (int v = 0; v < NV; v++) begin
      logic [NO-1:0] x;
      x = NO'(v);
      ex_tab[v] = x;
      case (mode)
        0: ap_tab[v] = x;
        1: ap_tab[v] = x & 4'b1110;
        2: ap_tab[v] = ~x;
        default: begin
          ex_tab[v] = NO'($urandom_range(0, 15));
          ap_tab[v] = ex_tab[v] ^ (($urandom_range(0, 3) == 0) ? NO'($urandom_range(1, 15)) : 4'd0);
        end
      endcase
    end
  endtask

  initial begin
    exp_t e;
    exp_t z;
    z.err = 0; z.hd = 0; z.abs_s = 0; z.mx = 0; z.dn = 0; z.start_cyc = 0; z.edges = 0;
    set_tables(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset pi", int'(pi1), 0);
    chk("reset busy", int'(busy1), 0);
    chk("reset done", int'(done1), 0);
    chk("reset err_cnt", int'(ec1), 0);
    chk("reset abs_sum dut3", int'(ab3), 0);

    run_full(1, "case1 identical");
    set_tables(1);
    run_full(1, "case2 lsb dropped");
    set_tables(2);
    run_full(1, "case3 inverted");

    // SETTLE=3: pi steps every 4 edges and start pulses inside WAIT are ignored.
    set_tables(1);
    e = model(NV);
    e.edges = 1 + NV * 4;
    start_sweep(3, e);
    for (int n = 1; n <= 12; n++) begin
      start3 = (n == 5 || n == 9) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      chk("dut3 pi step", int'(pi3), n / 4);
    end
    start3 = 1'b0;
    wait_end(3, NV * 4 + 20, "case4 settle3");

    // Abort on a sample edge once pi has reached 40: vectors 0..39 counted.
    e = model(40);
    e.dn = 0;
    start_sweep(1, e);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (pi1 == 7'd40) break;
    end
    chk("abort reach pi", int'(pi1), 40);
    @(posedge clk);
    #1;
    abort1 = 1'b1;
    @(posedge clk);
    #1;
    abort1 = 1'b0;
    chk("abort busy", int'(busy1), 0);
    chk("abort done", int'(done1), 0);
    chk("abort pi hold", int'(pi1), 40);
    @(negedge clk);
    @(negedge clk);
    chk("abort partial err_cnt", int'(ec1), 20);
    run_full(1, "case5 after abort");

    // Reset mid-sweep, then complete and restart from DONE.
    set_tables(2);
    start_sweep(1, z);
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset pi", int'(pi1), 0);
    chk("midreset busy", int'(busy1), 0);
    chk("midreset hd_sum", int'(hd1), 0);
    chk("midreset max_abs", int'(mx1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_full(1, "case6 first");
    e = model(NV);
    e.edges = 1 + NV * 2;
    start_sweep(1, e);
    chk("restart clears err_cnt", int'(ec1), 0);
    chk("restart clears abs_sum", int'(ab1), 0);
    chk("restart busy", int'(busy1), 1);
    chk("restart done", int'(done1), 0);
    wait_end(1, NV * 2 + 20, "case6 restart");

    for (int r = 0; r < 4; r++) begin
      set_tables(3);
      run_full((r % 2 == 0) ? 1 : 3, "random");
    end

    chk("queue1 drained", q1.size(), 0);
    chk("queue3 drained", q3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
